// File: rtl/alap_pkg.sv
// Shared definitions for the ALAP control unit and its datapath: opcodes,
// control-word layout and result FSM encoding.
package alap_pkg;

    localparam logic [3:0] F1_PASSA = 4'h0;
    localparam logic [3:0] F1_ADD   = 4'h1;
    localparam logic [3:0] F1_SUB   = 4'h2;
    localparam logic [3:0] F1_RSUB  = 4'h3;
    localparam logic [3:0] F1_AND   = 4'h4;
    localparam logic [3:0] F1_OR    = 4'h5;
    localparam logic [3:0] F1_XOR   = 4'h6;
    localparam logic [3:0] F1_NOTA  = 4'h7;
    localparam logic [3:0] F1_SHL   = 4'h8;
    localparam logic [3:0] F1_SHR   = 4'h9;
    localparam logic [3:0] F1_SRA   = 4'hA;
    localparam logic [3:0] F1_MIN   = 4'hB;
    localparam logic [3:0] F1_MAX   = 4'hC;
    localparam logic [3:0] F1_MUL   = 4'hD;
    localparam logic [3:0] F1_ABS   = 4'hE;
    localparam logic [3:0] F1_PASSB = 4'hF;

    localparam logic [1:0] F2_PASS3 = 2'd0;
    localparam logic [1:0] F2_SHL2  = 2'd1;
    localparam logic [1:0] F2_ADD31 = 2'd2;
    localparam logic [1:0] F2_SUB31 = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_t;

    // Control word as issued by the control unit, MSB first.
    typedef struct packed {
        logic       done;
        logic [1:0] f2_f;
        logic [3:0] f1_f;
        logic       r3_en;
        logic       r2_en;
        logic       r1_en;
        logic       r2_sel;
        logic       f2_oe;
        logic       f1_oe;
        logic       in1_oe;
        logic       in0_oe;
    } alap_cw_t;

    localparam int CW_W = $bits(alap_cw_t);

endpackage

// File: rtl/alap_alu.sv
// F1 functional unit: purely combinational, A = R1, B = R2.
module alap_alu
    import alap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_f,
    output logic [WIDTH-1:0] o_y
);

    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;
    logic [WIDTH-1:0]        w_mul;

    assign w_sa  = i_a;
    assign w_sb  = i_b;
    assign w_mul = i_a * i_b;

    always_comb begin
        o_y = '0;
        case (i_f)
            F1_PASSA: o_y = i_a;
            F1_ADD:   o_y = i_a + i_b;
            F1_SUB:   o_y = i_a - i_b;
            F1_RSUB:  o_y = i_b - i_a;
            F1_AND:   o_y = i_a & i_b;
            F1_OR:    o_y = i_a | i_b;
            F1_XOR:   o_y = i_a ^ i_b;
            F1_NOTA:  o_y = ~i_a;
            F1_SHL:   o_y = i_a << 1;
            F1_SHR:   o_y = i_a >> 1;
            F1_SRA:   o_y = $unsigned(w_sa >>> 1);
            F1_MIN:   o_y = (w_sa < w_sb) ? i_a : i_b;
            F1_MAX:   o_y = (w_sa > w_sb) ? i_a : i_b;
            F1_MUL:   o_y = w_mul;
            // The most negative value negates to itself, which is the wanted result.
            F1_ABS:   o_y = w_sa[WIDTH-1] ? ({WIDTH{1'b0}} - i_a) : i_a;
            F1_PASSB: o_y = i_b;
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/alap_dp.sv
// Datapath slave of the ALAP control unit: buses, R1-R3, F1/F2 and a one-deep
// result register with valid/ready handshake plus sticky error flags.
module alap_dp
    import alap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             in0_oe,
    input  logic             in1_oe,
    input  logic             f1_oe,
    input  logic             f2_oe,
    input  logic             r2_sel,
    input  logic             r1_en,
    input  logic             r2_en,
    input  logic             r3_en,
    input  logic [3:0]       f1_f,
    input  logic [1:0]       f2_f,
    input  logic             done,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             zero,
    output logic             err_bus,
    output logic             err_ovr,
    input  logic             err_clr
);

    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_r3;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_err_bus;
    logic             r_err_ovr;
    res_state_t       r_state;
    res_state_t       w_state_nxt;

    logic [WIDTH-1:0] w_f1;
    logic [WIDTH-1:0] w_f2;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_conflict;
    logic             w_capture;
    logic             w_ovr;

    alap_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a (r_r1),
        .i_b (r_r2),
        .i_f (f1_f),
        .o_y (w_f1)
    );

    always_comb begin
        w_f2 = r_r3;
        case (f2_f)
            F2_PASS3: w_f2 = r_r3;
            F2_SHL2:  w_f2 = r_r2 << 1;
            F2_ADD31: w_f2 = r_r3 + r_r1;
            F2_SUB31: w_f2 = r_r3 - r_r1;
            default:  w_f2 = r_r3;
        endcase
    end

    // On a drive conflict the external input keeps the bus.
    assign w_x        = in0_oe ? in0 : (f1_oe ? w_f1 : '0);
    assign w_y        = in1_oe ? in1 : (f2_oe ? w_f2 : '0);
    assign w_conflict = (in0_oe & f1_oe) | (in1_oe & f2_oe);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ovr       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (res_ready && done) begin
                    w_capture = 1'b1;
                end else if (res_ready) begin
                    w_state_nxt = ST_EMPTY;
                end else if (done) begin
                    w_ovr = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r1      <= '0;
            r_r2      <= '0;
            r_r3      <= '0;
            r_res     <= '0;
            r_zero    <= 1'b1;
            r_err_bus <= 1'b0;
            r_err_ovr <= 1'b0;
            r_state   <= ST_EMPTY;
        end else begin
            if (r1_en) r_r1 <= w_x;
            if (r2_en) r_r2 <= r2_sel ? w_x : w_y;
            if (r3_en) r_r3 <= w_x;
            if (w_capture) r_res <= r_r3;
            r_zero  <= (r_r3 == '0);
            r_state <= w_state_nxt;
            // A new error in the clearing cycle takes priority over the clear.
            if (w_conflict)   r_err_bus <= 1'b1;
            else if (err_clr) r_err_bus <= 1'b0;
            if (w_ovr)        r_err_ovr <= 1'b1;
            else if (err_clr) r_err_ovr <= 1'b0;
        end
    end

    assign res       = r_res;
    assign res_valid = (r_state == ST_FULL);
    assign zero      = r_zero;
    assign err_bus   = r_err_bus;
    assign err_ovr   = r_err_ovr;

endmodule

// File: tb/tb_alap_dp.sv
// Directed bench for alap_dp: inputs change 1 time unit after the rising edge,
// outputs are checked just before the next edge changes them again.
module tb_alap_dp;
    import alap_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in0, in1;
    logic             in0_oe, in1_oe, f1_oe, f2_oe, r2_sel;
    logic             r1_en, r2_en, r3_en;
    logic [3:0]       f1_f;
    logic [1:0]       f2_f;
    logic             done, res_ready, err_clr;
    logic [WIDTH-1:0] res;
    logic             res_valid, zero, err_bus, err_ovr;

    int total = 0;
    int bad   = 0;

    alap_dp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (in0),
        .in1       (in1),
        .in0_oe    (in0_oe),
        .in1_oe    (in1_oe),
        .f1_oe     (f1_oe),
        .f2_oe     (f2_oe),
        .r2_sel    (r2_sel),
        .r1_en     (r1_en),
        .r2_en     (r2_en),
        .r3_en     (r3_en),
        .f1_f      (f1_f),
        .f2_f      (f2_f),
        .done      (done),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .zero      (zero),
        .err_bus   (err_bus),
        .err_ovr   (err_ovr),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in0 = '0; in1 = '0;
        in0_oe = 0; in1_oe = 0; f1_oe = 0; f2_oe = 0; r2_sel = 0;
        r1_en = 0; r2_en = 0; r3_en = 0;
        f1_f = '0; f2_f = '0;
        done = 0; res_ready = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if (res !== 32'h0 || res_valid !== 1'b0 || zero !== 1'b1 ||
            err_bus !== 1'b0 || err_ovr !== 1'b0) begin
            bad++;
            $display("FAIL reset: res=%h valid=%b zero=%b eb=%b eo=%b, want 0/0/1/0/0",
                     res, res_valid, zero, err_bus, err_ovr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        idle();
        in0 = 5; in1 = 3; in0_oe = 1; in1_oe = 1; r1_en = 1; r2_en = 1;
        tick();
        idle();
        f1_oe = 1; f1_f = F1_ADD; r3_en = 1;
        tick();
        idle();
        done = 1;
        tick();
        total++;
        if (res !== 32'd8 || res_valid !== 1'b1 || zero !== 1'b0) begin
            bad++;
            $display("FAIL load_add: res=%0d valid=%b zero=%b, want 8/1/0", res, res_valid, zero);
        end
        idle();
        res_ready = 1;
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_release: valid=%b, want 0", res_valid);
        end
        idle();
    endtask

    task automatic test_f1_sweep();
        logic [WIDTH-1:0] exp_tab [16];
        exp_tab[0]  = 32'h8000_0000; exp_tab[1]  = 32'h8000_0001;
        exp_tab[2]  = 32'h7FFF_FFFF; exp_tab[3]  = 32'h8000_0001;
        exp_tab[4]  = 32'h0000_0000; exp_tab[5]  = 32'h8000_0001;
        exp_tab[6]  = 32'h8000_0001; exp_tab[7]  = 32'h7FFF_FFFF;
        exp_tab[8]  = 32'h0000_0000; exp_tab[9]  = 32'h4000_0000;
        exp_tab[10] = 32'hC000_0000; exp_tab[11] = 32'h8000_0000;
        exp_tab[12] = 32'h0000_0001; exp_tab[13] = 32'h8000_0000;
        exp_tab[14] = 32'h8000_0000; exp_tab[15] = 32'h0000_0001;
        idle();
        in0 = 32'h8000_0000; in1 = 32'h1; in0_oe = 1; in1_oe = 1; r1_en = 1; r2_en = 1;
        tick();
        for (int k = 0; k < 16; k++) begin
            idle();
            f1_oe = 1; f1_f = 4'(k); r3_en = 1;
            tick();
            idle();
            done = 1;
            tick();
            total++;
            if (res !== exp_tab[k] || res_valid !== 1'b1 || zero !== (exp_tab[k] == '0)) begin
                bad++;
                $display("FAIL f1_op%0h: res=%h valid=%b zero=%b, want %h/1/%b",
                         k, res, res_valid, zero, exp_tab[k], (exp_tab[k] == '0));
            end
            idle();
            res_ready = 1;
            tick();
        end
        idle();
    endtask

    task automatic test_f2();
        logic [1:0]       ops [4];
        logic [WIDTH-1:0] exps [4];
        ops[0] = F2_ADD31; exps[0] = 32'd15;
        ops[1] = F2_SUB31; exps[1] = 32'd10;
        ops[2] = F2_SHL2;  exps[2] = 32'd20;
        ops[3] = F2_PASS3; exps[3] = 32'd20;
        idle();
        in0 = 6; in1 = 99; in0_oe = 1; in1_oe = 1; r2_en = 1; r2_sel = 1;
        tick();
        idle();
        f1_oe = 1; f1_f = F1_PASSB; r3_en = 1;
        tick();
        idle();
        done = 1;
        tick();
        total++;
        if (res !== 32'd6) begin
            bad++;
            $display("FAIL r2_sel_x: res=%0d, want 6", res);
        end
        idle();
        res_ready = 1;
        in0 = 5; in0_oe = 1; r1_en = 1;
        tick();
        idle();
        in0 = 10; in0_oe = 1; r3_en = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            idle();
            f2_oe = 1; f2_f = ops[k]; r2_en = 1;
            tick();
            idle();
            f1_oe = 1; f1_f = F1_PASSB; r3_en = 1;
            tick();
            idle();
            done = 1;
            tick();
            total++;
            if (res !== exps[k]) begin
                bad++;
                $display("FAIL f2_op%0d: res=%0d, want %0d", ops[k], res, exps[k]);
            end
            idle();
            res_ready = 1;
            tick();
        end
        idle();
    endtask

    task automatic test_conflict();
        idle();
        in0 = 7; in0_oe = 1; f1_oe = 1; f1_f = F1_NOTA; r1_en = 1;
        tick();
        total++;
        if (err_bus !== 1'b1) begin
            bad++;
            $display("FAIL conflict_flag: err_bus=%b, want 1", err_bus);
        end
        idle();
        f1_oe = 1; f1_f = F1_PASSA; r3_en = 1;
        tick();
        idle();
        done = 1;
        tick();
        total++;
        if (res !== 32'd7 || err_bus !== 1'b1) begin
            bad++;
            $display("FAIL conflict_r1: res=%0d err_bus=%b, want 7/1", res, err_bus);
        end
        idle();
        res_ready = 1;
        in1 = 1; in1_oe = 1; f2_oe = 1; err_clr = 1;
        tick();
        total++;
        if (err_bus !== 1'b1) begin
            bad++;
            $display("FAIL conflict_set_wins: err_bus=%b, want 1", err_bus);
        end
        idle();
        err_clr = 1;
        tick();
        total++;
        if (err_bus !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL conflict_clear: err_bus=%b valid=%b, want 0/0", err_bus, res_valid);
        end
        idle();
    endtask

    task automatic test_handshake();
        idle();
        in0 = 42; in0_oe = 1; r3_en = 1;
        tick();
        idle();
        done = 1;
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (res !== 32'd42 || res_valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_%0d: res=%0d valid=%b, want 42/1", k, res, res_valid);
            end
            tick();
        end
        res_ready = 1;
        tick();
        total++;
        if (res_valid !== 1'b0 || res !== 32'd42) begin
            bad++;
            $display("FAIL handshake_drop: valid=%b res=%0d, want 0/42", res_valid, res);
        end
        idle();
    endtask

    task automatic test_overrun();
        idle();
        in0 = 42; in0_oe = 1; r3_en = 1;
        tick();
        idle();
        done = 1;
        tick();
        idle();
        in0 = 9; in0_oe = 1; r3_en = 1;
        tick();
        idle();
        done = 1;
        tick();
        total++;
        if (res !== 32'd42 || err_ovr !== 1'b1 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL overrun: res=%0d err_ovr=%b valid=%b, want 42/1/1", res, err_ovr, res_valid);
        end
        idle();
        done = 1; err_clr = 1;
        tick();
        total++;
        if (err_ovr !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set_wins: err_ovr=%b, want 1", err_ovr);
        end
        idle();
        err_clr = 1;
        tick();
        total++;
        if (err_ovr !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clear: err_ovr=%b, want 0", err_ovr);
        end
        idle();
        done = 1; res_ready = 1;
        tick();
        total++;
        if (res !== 32'd9 || err_ovr !== 1'b0 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back: res=%0d err_ovr=%b valid=%b, want 9/0/1", res, err_ovr, res_valid);
        end
        idle();
        res_ready = 1;
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_release: valid=%b, want 0", res_valid);
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        in0 = 42; in0_oe = 1; r3_en = 1;
        tick();
        idle();
        done = 1;
        in0 = 1; in0_oe = 1; f1_oe = 1;
        tick();
        idle();
        in0 = 3; in0_oe = 1; r1_en = 1; f1_oe = 1;
        tick();
        idle();
        in0 = 77; in0_oe = 1; r3_en = 1;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (res !== 32'h0 || res_valid !== 1'b0 || zero !== 1'b1 ||
            err_bus !== 1'b0 || err_ovr !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: res=%h valid=%b zero=%b eb=%b eo=%b, want 0/0/1/0/0",
                     res, res_valid, zero, err_bus, err_ovr);
        end
        idle();
        tick();
        rst_n = 1'b1;
        done = 1;
        tick();
        total++;
        if (res !== 32'h0 || res_valid !== 1'b1 || zero !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_r3: res=%h valid=%b zero=%b, want 0/1/1", res, res_valid, zero);
        end
        idle();
        res_ready = 1;
        tick();
        idle();
    endtask

    initial begin
        test_reset();
        test_load();
        test_f1_sweep();
        test_f2();
        test_conflict();
        test_handshake();
        test_overrun();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alap_dp.md
# alap_dp

Datapath slave for the ALAP-scheduled control unit of the FPU design. It consumes the control word the control unit issues each cycle: bus output enables, register enables, the R2 source select, and the F1/F2 function codes. It executes the scheduled operation sequence on registers R1–R3 and, on `done`, latches R3 into a result register that is offered downstream through a valid/ready handshake. It also flags illegal control words and result overruns.

## Interface

**Parameters**
- `WIDTH`, default 32: data width of inputs, registers, functional units and result.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in0`, in, WIDTH: operand 0.
- `in1`, in, WIDTH: operand 1.
- `in0_oe`, `in1_oe`, `f1_oe`, `f2_oe`, in, 1 each: bus drive enables from the control unit.
- `r2_sel`, in, 1: R2 source select; 1 = bus X, 0 = bus Y.
- `r1_en`, `r2_en`, `r3_en`, in, 1 each: register load enables.
- `f1_f`, in, 4: F1 function code.
- `f2_f`, in, 2: F2 function code.
- `done`, in, 1: end-of-schedule strobe from the control unit.
- `res`, out, WIDTH: captured result.
- `res_valid`, out, 1: `res` holds an unconsumed result.
- `res_ready`, in, 1: downstream accepts `res`.
- `zero`, out, 1: registered; R3 == 0.
- `err_bus`, out, 1: sticky; illegal bus drive was seen.
- `err_ovr`, out, 1: sticky; result was dropped.
- `err_clr`, in, 1: synchronous clear of both sticky errors.

## Operation

**Buses** (combinational)
- X = `in0` if `in0_oe`, else F1 if `f1_oe`, else 0.
- Y = `in1` if `in1_oe`, else F2 if `f2_oe`, else 0.
- `in0_oe & f1_oe`, or `in1_oe & f2_oe`, is a conflict. The input wins and `err_bus` is set.

**Registers**
- `r1_en`: R1 ← X.
- `r2_en`: R2 ← (`r2_sel` ? X : Y).
- `r3_en`: R3 ← X.
- Any combination of enables may be active in the same cycle. Unenabled registers hold.

**F1** (A = R1, B = R2, arithmetic mod 2^WIDTH, signed where noted)
- 0000 A; 0001 A+B; 0010 A−B; 0011 B−A; 0100 A&B; 0101 A|B; 0110 A^B; 0111 ~A.
- 1000 A<<1; 1001 A>>1 (logical); 1010 A>>>1 (arithmetic); 1011 signed min; 1100 signed max.
- 1101 low WIDTH bits of A*B; 1110 |A| (most negative value maps to itself); 1111 B.

**F2**
- 00 R3; 01 R2<<1; 10 R3+R1; 11 R3−R1.

**Result FSM**
- EMPTY: on `done`, `res` ← R3 (pre-edge value), go to FULL.
- FULL: `res_valid`=1.
  - `res_ready` without `done`: go to EMPTY.
  - `res_ready` with `done`: capture the new R3 and stay FULL; no error.
  - `done` without `res_ready`: keep the old `res`, set `err_ovr`.
- `err_clr`: clears both sticky errors. A set event in the same cycle wins.

**Reset** (`rst_n` low): R1–R3 = 0, `res` = 0, state EMPTY, `res_valid` = 0, `zero` = 1, `err_bus` = 0, `err_ovr` = 0. Reset asserted mid-schedule aborts the operation and drops any pending result.

## Timing
- Bus and functional-unit paths are combinational from register outputs and control inputs to register D pins. One schedule step per cycle.
- A register loaded in cycle N is visible to F1/F2 in cycle N+1.
- `res_valid` rises on the edge ending the `done` cycle and falls on the edge ending the first cycle with `res_ready`=1.
- `zero` tracks R3 with one cycle of latency.
- `err_*` assert on the edge after the offending cycle.
- Full control-unit schedule: 9 cycles from `go` to `done`; `res_valid` appears at cycle 10.

## Structure
- Shared package `alap_pkg`: F1 opcode constants (`F1_PASSA`…`F1_PASSB`), F2 opcode constants, result FSM state encoding.
- The control-unit control-word field order belongs in the same package, so both ends share one definition.
- One sub-module: `alap_alu`, the combinational F1 unit (WIDTH, A, B, f → Y). F2, buses, registers and the FSM live in `alap_dp`.

## Test plan
- Load: `in0`=5, `in1`=3, `in0_oe`=`in1_oe`=`r1_en`=`r2_en`=1 → next cycle R1=5, R2=3; F1 with `f1_f`=0001 gives 8.
- F1 sweep: A=0x8000_0000, B=1, every `f1_f` → 1010 gives 0xC000_0000, 1110 gives 0x8000_0000, 1101 gives 0x8000_0000, 1011 gives 0x8000_0000.
- Conflict: `in0_oe`=`f1_oe`=1 with `r1_en`, `in0`=7 → R1=7, `err_bus`=1 until `err_clr`.
- Handshake: `done` with R3=42, `res_ready`=0 for 3 cycles → `res`=42 held, `res_valid` stays 1; `res_ready`=1 → `res_valid`=0 next cycle.
- Overrun: second `done` with R3=9 while FULL and `res_ready`=0 → `res`=42, `err_ovr`=1. Repeat with `res_ready`=1 → `res`=9, no error.
- Reset: deassert `rst_n` mid-schedule with `res_valid`=1 → all outputs at reset values immediately, without waiting for a clock edge.
